// File: rtl/sr_bank_ctrl.sv
// Round-robin sequencer that shares a bank of SR flip-flops between requesters.
// It drives registered one-hot s/r pulses of PULSE cycles, each followed by one idle gap cycle.
module sr_bank_ctrl #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3,
  parameter int PULSE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [AW*NREQ-1:0]   addr,
  input  logic [NBITS-1:0]     q_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     s,
  output logic [NBITS-1:0]     r,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_TOG   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [PW-1:0]  win;
  logic [1:0]     w_op;
  logic [AW-1:0]  w_addr;
  logic           w_valid;
  logic [NBITS-1:0] w_onehot;
  logic           w_q;

  // Handshake: a requester holds req/op/addr until its one-cycle gnt pulse, then
  // drops req; req is only sampled in IDLE, so a level still high later is a new command.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_op     = op[2*win +: 2];
    w_addr   = addr[AW*win +: AW];
    w_valid  = (w_op != 2'b00) && (int'(w_addr) < NBITS);
    // Out-of-range addresses shift off the top, leaving no bit selected.
    w_onehot = NBITS'(1) << w_addr;
    w_q      = |(q_in & w_onehot);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      gnt    <= '0;
      s      <= '0;
      r      <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << win;
            rr_ptr <= PW'((int'(win) + 1) % NREQ);
            busy   <= 1'b1;
            if (w_valid) begin
              state <= DRIVE;
              cnt   <= CW'(PULSE - 1);
              case (w_op)
                OP_SET:   s <= w_onehot;
                OP_CLEAR: r <= w_onehot;
                OP_TOG: begin
                  if (w_q) r <= w_onehot;
                  else     s <= w_onehot;
                end
                default: begin
                  s <= '0;
                  r <= '0;
                end
              endcase
            end else begin
              err   <= 1'b1;
              state <= GAP;
            end
          end
        end
        DRIVE: begin
          // The grant edge counts as the first pulse cycle.
          if (cnt == '0) begin
            s     <= '0;
            r     <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          s     <= '0;
          r     <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl with a continuous s/r exclusivity monitor.
module tb_sr_bank_ctrl;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int AW    = 4;
  localparam int PULSE = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   op;
  logic [AW*NREQ-1:0]  addr;
  logic [NBITS-1:0]    q_in;
  logic [NREQ-1:0]     gnt;
  logic [NBITS-1:0]    s;
  logic [NBITS-1:0]    r;
  logic                busy;
  logic                err;
  logic [1:0]          dbg_state;

  int vectors = 0;
  int miscompares = 0;

  sr_bank_ctrl #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW), .PULSE(PULSE)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .q_in(q_in),
    .gnt(gnt), .s(s), .r(r), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [AW-1:0] a);
    op[2*i +: 2]   = o;
    addr[AW*i +: AW] = a;
    req[i]         = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_s,
                         input logic [7:0] e_r, input logic e_busy, input logic e_err,
                         input logic [1:0] e_state);
    chk({tag, ".gnt"},   32'(gnt),       32'(e_gnt));
    chk({tag, ".s"},     32'(s),         32'(e_s));
    chk({tag, ".r"},     32'(r),         32'(e_r));
    chk({tag, ".busy"},  32'(busy),      32'(e_busy));
    chk({tag, ".err"},   32'(err),       32'(e_err));
    chk({tag, ".state"}, 32'(dbg_state), 32'(e_state));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      vectors++;
      assert (((s & r) == '0) && ($countones(s | r) <= 1)) else begin
        miscompares++;
        $error("FAIL invariant observed s=%0h r=%0h expected disjoint and at most one bit", s, r);
      end
    end
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    op    = '0;
    addr  = '0;
    q_in  = '0;
    #12;
    chk_out("reset", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    cyc();
    chk_out("idle", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

    // single set from requester 1 at bit 5
    set_req(1, 2'b01, 4'd5);
    cyc();
    chk_out("set.c0", 4'b0010, 8'h20, 8'h00, 1'b1, 1'b0, 2'd1);
    req = '0;
    cyc();
    chk_out("set.c1", 4'b0000, 8'h20, 8'h00, 1'b1, 1'b0, 2'd1);
    cyc();
    chk_out("set.gap", 4'b0000, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2);
    cyc();
    chk_out("set.idle", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

    // toggle with q=1 clears; rr_ptr=2 so search wraps to requester 0
    q_in = 8'h04;
    set_req(0, 2'b11, 4'd2);
    cyc();
    chk_out("tog1.c0", 4'b0001, 8'h00, 8'h04, 1'b1, 1'b0, 2'd1);
    req = '0;
    cyc();
    chk_out("tog1.c1", 4'b0000, 8'h00, 8'h04, 1'b1, 1'b0, 2'd1);
    cyc();
    cyc();
    chk_out("tog1.idle", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

    q_in = 8'hFB;
    set_req(0, 2'b11, 4'd2);
    cyc();
    chk_out("tog0.c0", 4'b0001, 8'h04, 8'h00, 1'b1, 1'b0, 2'd1);
    req = '0;
    cyc();
    chk_out("tog0.c1", 4'b0000, 8'h04, 8'h00, 1'b1, 1'b0, 2'd1);
    cyc();
    chk_out("tog0.gap", 4'b0000, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2);
    cyc();

    // invalid op, then out-of-range address
    set_req(3, 2'b00, 4'd1);
    cyc();
    chk_out("inv_op.c0", 4'b1000, 8'h00, 8'h00, 1'b1, 1'b1, 2'd2);
    req = '0;
    cyc();
    chk_out("inv_op.idle", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    set_req(3, 2'b01, 4'd9);
    cyc();
    chk_out("inv_addr.c0", 4'b1000, 8'h00, 8'h00, 1'b1, 1'b1, 2'd2);
    req = '0;
    cyc();
    chk_out("inv_addr.idle", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

    // round robin with all requests held, rr_ptr=0
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 4'(i + 4));
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out($sformatf("rr%0d.grant", k), 4'(1 << (k % 4)), 8'(1 << ((k % 4) + 4)),
              8'h00, 1'b1, 1'b0, 2'd1);
      cyc();
      chk($sformatf("rr%0d.hold_gnt", k), 32'(gnt), 32'h0);
      cyc();
      chk($sformatf("rr%0d.gap_s", k), 32'(s), 32'h0);
      cyc();
      chk($sformatf("rr%0d.idle_busy", k), 32'(busy), 32'h0);
      if (k == 4) req = '0;
    end

    // async reset mid-DRIVE; rr_ptr=1 so requester 2 wins and would leave rr_ptr=3
    set_req(2, 2'b01, 4'd3);
    cyc();
    chk_out("rst.drive", 4'b0100, 8'h08, 8'h00, 1'b1, 1'b0, 2'd1);
    req = '0;
    #1 reset = 1'b0;
    #1;
    chk_out("rst.async", 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    #3 reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b10, 4'(i));
    cyc();
    chk_out("rst.first", 4'b0001, 8'h00, 8'h01, 1'b1, 1'b0, 2'd1);
    req = '0;
    cyc();
    cyc();
    cyc();

    // random traffic; the negedge monitor checks s/r exclusivity
    for (int n = 0; n < 400; n++) begin
      req  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      op   = (2*NREQ)'($urandom);
      addr = (AW*NREQ)'($urandom);
      q_in = NBITS'($urandom);
      cyc();
    end
    req = '0;
    for (int n = 0; n < PULSE + 2; n++) cyc();
    chk("final.busy", 32'(busy), 32'h0);
    chk("final.state", 32'(dbg_state), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
